// File: rtl/spi_command_router.sv
// spi_command_router: decodes the first byte of each chip-select-low SPI
// transaction and either streams record bytes to one of NumChannels FIFOs,
// returns a status readout, clears the sticky error flags, or discards the
// rest of the transaction. Records are admitted or dropped as a whole.
module spi_command_router #(
  parameter int NumChannels = 2,
  parameter int RecordBytes = 16,
  parameter int SlotBits    = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_spi_cs,
  input  logic [7:0]                      i_rx_data,
  input  logic                            i_rx_valid,
  output logic [7:0]                      o_tx_data,
  output logic [NumChannels-1:0]          o_fifo_write_en,
  output logic [7:0]                      o_fifo_data,
  input  logic [NumChannels*SlotBits-1:0] i_fifo_free_slots,
  output logic [2:0]                      o_error_flags
);

  localparam int ChW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int CntW = $clog2(RecordBytes);
  localparam int IdxW = $clog2(NumChannels + 2);
  localparam int ExtW = SlotBits + 8;

  localparam logic [4:0]      NumChCmd   = 5'(NumChannels);
  localparam logic [IdxW-1:0] IdxNumCh   = IdxW'(NumChannels);
  localparam logic [IdxW-1:0] IdxSat     = IdxW'(NumChannels + 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(RecordBytes - 1);
  localparam logic [7:0]      CmdStatus  = 8'h00;
  localparam logic [7:0]      CmdClear   = 8'h7F;

  // Flag bit positions inside {bad_cmd, truncated, overflow}
  localparam int FlagBad   = 2;
  localparam int FlagTrunc = 1;
  localparam int FlagOvf   = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STATUS  = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CntW-1:0]         r_byte_cnt;
  logic [IdxW-1:0]         r_status_idx;
  logic [ChW-1:0]          r_ch;
  logic                    r_accept;
  logic [7:0]              r_tx_data;
  logic [NumChannels-1:0]  r_fifo_write_en;
  logic [7:0]              r_fifo_data;
  logic [2:0]              r_error_flags;

  state_t                  w_state_nxt;
  logic [CntW-1:0]         w_byte_cnt_nxt;
  logic [IdxW-1:0]         w_status_idx_nxt;
  logic [ChW-1:0]          w_ch_nxt;
  logic                    w_accept_nxt;
  logic                    w_accept;
  logic [7:0]              w_tx_nxt;
  logic [NumChannels-1:0]  w_wen_nxt;
  logic [7:0]              w_fdata_nxt;
  logic [2:0]              w_flag_set;
  logic                    w_flag_clr;
  logic [2:0]              w_flags_nxt;
  logic                    w_is_write_cmd;
  logic [SlotBits-1:0]     w_free0;
  logic [SlotBits-1:0]     w_free_ch;
  logic [SlotBits-1:0]     w_free_chn;
  logic [SlotBits-1:0]     w_free_idx;

  // Map a free-slot count onto a tx byte, optionally saturating at 255
  function automatic logic [7:0] to_byte(input logic [SlotBits-1:0] v, input logic sat);
    logic [ExtW-1:0] ext;
    ext = {8'h00, v};
    if (sat && (ext > ExtW'(255))) begin
      to_byte = 8'hFF;
    end else begin
      to_byte = ext[7:0];
    end
  endfunction

  // Free-slot counts of channel 0 and of the channel currently being written
  always_comb begin
    w_free0   = i_fifo_free_slots[SlotBits-1:0];
    w_free_ch = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_free_ch = (r_ch == ChW'(i)) ? i_fifo_free_slots[i*SlotBits +: SlotBits] : w_free_ch;
    end
  end

  assign w_is_write_cmd = (i_rx_data[7:4] == 4'h1) && ({1'b0, i_rx_data[3:0]} < NumChCmd);
  // Admission is decided on the first byte of a record and held for the rest of it
  assign w_accept       = (r_byte_cnt == '0) ? (w_free_ch != '0) : r_accept;

  // Next-state, datapath and flag-event decode
  always_comb begin
    w_state_nxt      = r_state;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_status_idx_nxt = r_status_idx;
    w_ch_nxt         = r_ch;
    w_accept_nxt     = r_accept;
    w_wen_nxt        = '0;
    w_fdata_nxt      = r_fifo_data;
    w_flag_set       = 3'b000;
    w_flag_clr       = 1'b0;
    if (i_spi_cs) begin
      // CS rising ends the transaction; a partial record is reported, not retracted
      w_state_nxt    = ST_IDLE;
      w_byte_cnt_nxt = '0;
      if ((r_state == ST_WRITE) && (r_byte_cnt != '0)) begin
        w_flag_set[FlagTrunc] = 1'b1;
      end else begin
        w_flag_set[FlagTrunc] = 1'b0;
      end
    end else if (i_rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (i_rx_data == CmdStatus) begin
            w_state_nxt      = ST_STATUS;
            w_status_idx_nxt = '0;
          end else if (w_is_write_cmd) begin
            w_state_nxt    = ST_WRITE;
            w_ch_nxt       = i_rx_data[ChW-1:0];
            w_byte_cnt_nxt = '0;
          end else if (i_rx_data == CmdClear) begin
            w_state_nxt = ST_DISCARD;
            w_flag_clr  = 1'b1;
          end else begin
            w_state_nxt         = ST_DISCARD;
            w_flag_set[FlagBad] = 1'b1;
          end
        end
        ST_STATUS: begin
          if (r_status_idx != IdxSat) begin
            w_status_idx_nxt = r_status_idx + IdxW'(1);
          end else begin
            w_status_idx_nxt = r_status_idx;
          end
        end
        ST_WRITE: begin
          w_fdata_nxt  = i_rx_data;
          w_accept_nxt = w_accept;
          if ((r_byte_cnt == '0) && !w_accept) begin
            w_flag_set[FlagOvf] = 1'b1;
          end else begin
            w_flag_set[FlagOvf] = 1'b0;
          end
          for (int i = 0; i < NumChannels; i++) begin
            w_wen_nxt[i] = w_accept && (r_ch == ChW'(i));
          end
          if (r_byte_cnt == CntLast) begin
            w_byte_cnt_nxt = '0;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + CntW'(1);
          end
        end
        ST_DISCARD: begin
          w_state_nxt = ST_DISCARD;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
    // A set in the same cycle as CLEAR wins
    w_flags_nxt = (w_flag_clr ? 3'b000 : r_error_flags) | w_flag_set;
  end

  // Byte presented for the next SPI transfer, chosen from the upcoming state
  always_comb begin
    w_free_idx = '0;
    w_free_chn = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_free_idx = (w_status_idx_nxt == IdxW'(i)) ? i_fifo_free_slots[i*SlotBits +: SlotBits] : w_free_idx;
      w_free_chn = (w_ch_nxt == ChW'(i)) ? i_fifo_free_slots[i*SlotBits +: SlotBits] : w_free_chn;
    end
    case (w_state_nxt)
      ST_IDLE: begin
        w_tx_nxt = to_byte(w_free0, 1'b1);
      end
      ST_STATUS: begin
        if (w_status_idx_nxt < IdxNumCh) begin
          w_tx_nxt = to_byte(w_free_idx, 1'b0);
        end else if (w_status_idx_nxt == IdxNumCh) begin
          w_tx_nxt = {5'b00000, w_flags_nxt};
        end else begin
          w_tx_nxt = 8'h00;
        end
      end
      ST_WRITE: begin
        w_tx_nxt = to_byte(w_free_chn, 1'b0);
      end
      ST_DISCARD: begin
        w_tx_nxt = 8'h00;
      end
      default: begin
        w_tx_nxt = 8'h00;
      end
    endcase
  end

  // State and output registers; reset overrides every other event
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_byte_cnt      <= '0;
      r_status_idx    <= '0;
      r_ch            <= '0;
      r_accept        <= 1'b0;
      r_tx_data       <= 8'h00;
      r_fifo_write_en <= '0;
      r_fifo_data     <= 8'h00;
      r_error_flags   <= 3'b000;
    end else begin
      r_state         <= w_state_nxt;
      r_byte_cnt      <= w_byte_cnt_nxt;
      r_status_idx    <= w_status_idx_nxt;
      r_ch            <= w_ch_nxt;
      r_accept        <= w_accept_nxt;
      r_tx_data       <= w_tx_nxt;
      r_fifo_write_en <= w_wen_nxt;
      r_fifo_data     <= w_fdata_nxt;
      r_error_flags   <= w_flags_nxt;
    end
  end

  assign o_tx_data       = r_tx_data;
  assign o_fifo_write_en = r_fifo_write_en;
  assign o_fifo_data     = r_fifo_data;
  assign o_error_flags   = r_error_flags;

endmodule

// File: tb/tb_spi_command_router.sv
// Directed bench for spi_command_router (2 channels, 16-byte records,
// 9-bit free counts so IDLE saturation can be exercised).
module tb_spi_command_router;

  localparam int NCh = 2;
  localparam int RB  = 16;
  localparam int SB  = 9;

  logic             clk;
  logic             reset;
  logic             spi_cs;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       tx_data;
  logic [NCh-1:0]   fifo_write_en;
  logic [7:0]       fifo_data;
  logic [8:0]       free0;
  logic [8:0]       free1;
  logic [2:0]       error_flags;

  int errors = 0;
  int checks = 0;

  spi_command_router #(.NumChannels(NCh), .RecordBytes(RB), .SlotBits(SB)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_spi_cs          (spi_cs),
    .i_rx_data         (rx_data),
    .i_rx_valid        (rx_valid),
    .o_tx_data         (tx_data),
    .o_fifo_write_en   (fifo_write_en),
    .o_fifo_data       (fifo_data),
    .i_fifo_free_slots ({free1, free0}),
    .o_error_flags     (error_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       v;
    logic [7:0] d;
    logic [8:0] f0;
    logic [8:0] f1;
    logic [7:0] tx;
    logic [1:0] wen;
    logic [7:0] fd;
    logic [2:0] fl;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Two idle cycles between bytes; no strobe may appear in the gap
  task automatic gap();
    tick();
    chk("gap_wen", 32'(fifo_write_en), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    spi_cs   = 1'b1;
    rx_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int strobes;
    reset = 1'b1; spi_cs = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    free0 = 9'd300; free1 = 9'd7;

    // Reset state
    tick();
    tick();
    chk("rst_tx", 32'(tx_data), 32'h00);
    chk("rst_wen", 32'(fifo_write_en), 32'h0);
    chk("rst_fd", 32'(fifo_data), 32'h00);
    chk("rst_fl", 32'(error_flags), 32'h0);
    reset = 1'b0;

    // Per-cycle vectors: bad commands, CLEAR, STATUS walk, saturation
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 9'd300, 9'd7, 8'hFF, 2'b00, 8'h00, 3'b000};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 9'd300, 9'd7, 8'hFF, 2'b00, 8'h00, 3'b000};
    vecs[2]  = '{1'b0, 1'b1, 8'h35, 9'd300, 9'd7, 8'h00, 2'b00, 8'h00, 3'b100};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 9'd300, 9'd7, 8'h00, 2'b00, 8'h00, 3'b100};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 9'd300, 9'd7, 8'hFF, 2'b00, 8'h00, 3'b100};
    vecs[5]  = '{1'b0, 1'b1, 8'h7F, 9'd300, 9'd7, 8'h00, 2'b00, 8'h00, 3'b000};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 9'd300, 9'd7, 8'hFF, 2'b00, 8'h00, 3'b000};
    vecs[7]  = '{1'b0, 1'b1, 8'h12, 9'd300, 9'd7, 8'h00, 2'b00, 8'h00, 3'b100};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 9'd300, 9'd7, 8'hFF, 2'b00, 8'h00, 3'b100};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 9'd5,   9'd7, 8'h05, 2'b00, 8'h00, 3'b100};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 9'd5,   9'd7, 8'h05, 2'b00, 8'h00, 3'b100};
    vecs[11] = '{1'b0, 1'b1, 8'hFF, 9'd5,   9'd7, 8'h07, 2'b00, 8'h00, 3'b100};
    vecs[12] = '{1'b0, 1'b1, 8'hFF, 9'd5,   9'd7, 8'h04, 2'b00, 8'h00, 3'b100};
    vecs[13] = '{1'b0, 1'b1, 8'hFF, 9'd5,   9'd7, 8'h00, 2'b00, 8'h00, 3'b100};
    vecs[14] = '{1'b0, 1'b1, 8'hFF, 9'd5,   9'd7, 8'h00, 2'b00, 8'h00, 3'b100};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 9'd5,   9'd7, 8'h05, 2'b00, 8'h00, 3'b100};
    vecs[16] = '{1'b0, 1'b1, 8'h7F, 9'd5,   9'd7, 8'h00, 2'b00, 8'h00, 3'b000};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 9'd5,   9'd7, 8'h05, 2'b00, 8'h00, 3'b000};
    vecs[18] = '{1'b0, 1'b1, 8'h11, 9'd5,   9'd7, 8'h07, 2'b00, 8'h00, 3'b000};
    vecs[19] = '{1'b1, 1'b0, 8'h00, 9'd5,   9'd7, 8'h05, 2'b00, 8'h00, 3'b000};

    for (int i = 0; i < 20; i++) begin
      spi_cs   = vecs[i].cs;
      rx_valid = vecs[i].v;
      rx_data  = vecs[i].d;
      free0    = vecs[i].f0;
      free1    = vecs[i].f1;
      tick();
      chk($sformatf("vec%0d_tx", i), 32'(tx_data), 32'(vecs[i].tx));
      chk($sformatf("vec%0d_wen", i), 32'(fifo_write_en), 32'(vecs[i].wen));
      chk($sformatf("vec%0d_fd", i), 32'(fifo_data), 32'(vecs[i].fd));
      chk($sformatf("vec%0d_fl", i), 32'(error_flags), 32'(vecs[i].fl));
    end
    rx_valid = 1'b0;

    // Reset in the middle of a WRITE record
    do_reset();
    free0 = 9'd4; free1 = 9'd9;
    spi_cs = 1'b0;
    tick();
    send(8'h10); gap();
    for (int i = 0; i < 3; i++) begin
      send(8'(8'h60 + i));
      chk("rw_wen", 32'(fifo_write_en), 32'h1);
      gap();
    end
    rx_data = 8'h55; rx_valid = 1'b1; reset = 1'b1;
    tick();
    chk("rw_rst_tx", 32'(tx_data), 32'h00);
    chk("rw_rst_wen", 32'(fifo_write_en), 32'h0);
    chk("rw_rst_fd", 32'(fifo_data), 32'h00);
    chk("rw_rst_fl", 32'(error_flags), 32'h0);
    reset = 1'b0; rx_valid = 1'b0;
    tick();
    chk("rw_after_wen", 32'(fifo_write_en), 32'h0);
    chk("rw_after_tx", 32'(tx_data), 32'h04);
    send(8'h00);
    chk("rw_stat0", 32'(tx_data), 32'h04);
    gap();
    send(8'hFF);
    chk("rw_stat1", 32'(tx_data), 32'h09);
    chk("rw_fl", 32'(error_flags), 32'h0);
    spi_cs = 1'b1; tick();

    // One full record on channel 1
    do_reset();
    free0 = 9'd5; free1 = 9'd3;
    spi_cs = 1'b0;
    tick();
    send(8'h11);
    chk("c1_cmd_tx", 32'(tx_data), 32'h03);
    gap();
    strobes = 0;
    for (int i = 0; i < RB; i++) begin
      send(8'(8'hA0 + i));
      chk($sformatf("c1_wen%0d", i), 32'(fifo_write_en), 32'h2);
      chk($sformatf("c1_fd%0d", i), 32'(fifo_data), 32'(8'hA0 + i));
      if (fifo_write_en == 2'b10) strobes++;
      gap();
    end
    chk("c1_strobes", 32'(strobes), 32'd16);
    chk("c1_fl", 32'(error_flags), 32'h0);
    spi_cs = 1'b1; tick();
    chk("c1_cs_fl", 32'(error_flags), 32'h0);

    // Two records on channel 0: first dropped for lack of space, second admitted
    do_reset();
    free0 = 9'd0; free1 = 9'd3;
    spi_cs = 1'b0;
    tick();
    send(8'h10); gap();
    strobes = 0;
    for (int i = 0; i < 2 * RB; i++) begin
      free0 = (i < RB) ? 9'd0 : 9'd1;
      send(8'(i));
      chk($sformatf("ov_wen%0d", i), 32'(fifo_write_en), (i < RB) ? 32'h0 : 32'h1);
      if (fifo_write_en != 2'b00) strobes++;
      gap();
    end
    chk("ov_strobes", 32'(strobes), 32'd16);
    chk("ov_fl", 32'(error_flags), 32'h1);
    spi_cs = 1'b1; tick();
    chk("ov_cs_fl", 32'(error_flags), 32'h1);

    // Truncated record, then a back-to-back STATUS readout
    do_reset();
    free0 = 9'd4; free1 = 9'd9;
    spi_cs = 1'b0;
    tick();
    send(8'h10); gap();
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      send(8'(8'hC0 + i));
      if (fifo_write_en == 2'b01) strobes++;
      gap();
    end
    chk("tr_strobes", 32'(strobes), 32'd5);
    spi_cs = 1'b1; tick();
    chk("tr_fl", 32'(error_flags), 32'h2);
    spi_cs = 1'b0;
    send(8'h00);
    chk("tr_st0", 32'(tx_data), 32'h04);
    gap();
    send(8'h00);
    chk("tr_st1", 32'(tx_data), 32'h09);
    gap();
    send(8'h00);
    chk("tr_st2", 32'(tx_data), 32'h02);
    gap();
    send(8'h00);
    chk("tr_st3", 32'(tx_data), 32'h00);
    chk("tr_st_wen", 32'(fifo_write_en), 32'h0);
    spi_cs = 1'b1; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
